// File: rtl/bmp_slicer.sv
// bmp_slicer: captures a ROWS x COLS bitmap in one load, then streams it
// over three valid/ready ports: columns ascending, rows top-down and
// bottom-up. In split mode the two row streams meet in the middle and
// together deliver every row exactly once.
module bmp_slicer #(
  parameter int ROWS       = 64,
  parameter int COLS       = 24,
  parameter int SPLIT_ROWS = 0,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wren,
  input  logic [ROWS*COLS-1:0] data,
  output logic                 loaded,
  output logic                 done,
  output logic                 col_valid,
  input  logic                 col_ready,
  output logic [ROWS-1:0]      col_data,
  output logic [CW-1:0]        col_idx,
  output logic                 col_last,
  output logic                 top_valid,
  input  logic                 top_ready,
  output logic [COLS-1:0]      top_data,
  output logic [RW-1:0]        top_idx,
  output logic                 top_last,
  output logic                 bot_valid,
  input  logic                 bot_ready,
  output logic [COLS-1:0]      bot_data,
  output logic [RW-1:0]        bot_idx,
  output logic                 bot_last
);

  logic [ROWS*COLS-1:0] bitmap;
  logic [COLS-1:0]      rows [ROWS];
  logic [ROWS-1:0]      col_raw;

  logic col_pend, top_pend, bot_pend;
  logic col_pend_nxt, top_pend_nxt, bot_pend_nxt;
  logic col_x, top_x, bot_x, bot_hs;
  logic row_fin, done_nxt;
  logic [RW:0] bot_nx, top_nx;

  for (genvar gr = 0; gr < ROWS; gr++) begin : g_rows
    assign rows[gr]    = bitmap[gr*COLS +: COLS];
    assign col_raw[gr] = rows[gr][col_idx];
  end

  // Bitmap storage: written only by a load, never cleared.
  always_ff @(posedge clk) begin
    if (!reset && wren) begin
      bitmap <= data;
    end
  end

  // Valid, last and data presentation from the registered state; handshakes
  // and the next pending flags that follow from them.
  always_comb begin
    col_valid = col_pend;
    bot_valid = bot_pend;
    top_valid = top_pend;
    if (SPLIT_ROWS != 0) begin
      bot_valid = bot_pend && (bot_idx <= top_idx);
      top_valid = top_pend && (top_idx > bot_idx);
    end

    // A handshake coinciding with a load is dropped: the load restarts everything.
    col_x  = col_valid && col_ready && !wren;
    top_x  = top_valid && top_ready && !wren;
    bot_x  = bot_valid && bot_ready && !wren;
    bot_hs = bot_valid && bot_ready;

    col_last = col_valid && (col_idx == CW'(COLS-1));
    bot_last = bot_valid && (bot_idx == RW'(ROWS-1));
    top_last = top_valid && (top_idx == '0);
    if (SPLIT_ROWS != 0) begin
      bot_last = bot_valid && (bot_idx == top_idx);
      // The top port only owns the final word if the bottom port does not
      // take its own row in the same cycle.
      top_last = top_valid && (top_idx == bot_idx + RW'(1)) && !bot_hs;
    end

    col_data = col_valid ? col_raw : '0;
    top_data = top_valid ? rows[top_idx] : '0;
    bot_data = bot_valid ? rows[bot_idx] : '0;

    // Extended-width post-transfer indices; rows are finished once they cross.
    bot_nx  = {1'b0, bot_idx} + {{RW{1'b0}}, bot_x};
    top_nx  = {1'b0, top_idx} - {{RW{1'b0}}, top_x};
    row_fin = (bot_x || top_x) && (bot_nx > top_nx);

    col_pend_nxt = col_pend && !(col_x && col_last);
    bot_pend_nxt = bot_pend && !(bot_x && bot_last);
    top_pend_nxt = top_pend && !(top_x && top_last);
    if (SPLIT_ROWS != 0) begin
      bot_pend_nxt = bot_pend && !row_fin;
      top_pend_nxt = top_pend && !row_fin;
    end

    done_nxt = done || ((col_pend || bot_pend || top_pend) &&
                        !(col_pend_nxt || bot_pend_nxt || top_pend_nxt));
  end

  // Stream control: load restarts all streams, transfers step the indices
  // without ever stepping past a stream's final value.
  always_ff @(posedge clk) begin
    if (reset) begin
      loaded   <= 1'b0;
      done     <= 1'b0;
      col_pend <= 1'b0;
      top_pend <= 1'b0;
      bot_pend <= 1'b0;
      col_idx  <= '0;
      bot_idx  <= '0;
      top_idx  <= RW'(ROWS-1);
    end else if (wren) begin
      loaded   <= 1'b1;
      done     <= 1'b0;
      col_pend <= 1'b1;
      top_pend <= 1'b1;
      bot_pend <= 1'b1;
      col_idx  <= '0;
      bot_idx  <= '0;
      top_idx  <= RW'(ROWS-1);
    end else begin
      loaded   <= 1'b0;
      done     <= done_nxt;
      col_pend <= col_pend_nxt;
      top_pend <= top_pend_nxt;
      bot_pend <= bot_pend_nxt;
      if (col_x && (col_idx != CW'(COLS-1))) begin
        col_idx <= col_idx + CW'(1);
      end
      if (bot_x && (bot_idx != RW'(ROWS-1))) begin
        bot_idx <= bot_idx + RW'(1);
      end
      if (top_x && (top_idx != '0)) begin
        top_idx <= top_idx - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_bmp_slicer.sv
// Directed bench for bmp_slicer: normal mode 4x3, split mode with 5 and 4 rows.
module tb_bmp_slicer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Normal mode, ROWS=4 COLS=3
  logic        n_wren, n_loaded, n_done;
  logic [11:0] n_data;
  logic        n_col_valid, n_col_ready, n_col_last;
  logic [3:0]  n_col_data;
  logic [1:0]  n_col_idx;
  logic        n_top_valid, n_top_ready, n_top_last;
  logic [2:0]  n_top_data;
  logic [1:0]  n_top_idx;
  logic        n_bot_valid, n_bot_ready, n_bot_last;
  logic [2:0]  n_bot_data;
  logic [1:0]  n_bot_idx;

  // Split mode, ROWS=5 COLS=3
  logic        s5_wren, s5_loaded, s5_done;
  logic [14:0] s5_data;
  logic        s5_col_valid, s5_col_ready, s5_col_last;
  logic [4:0]  s5_col_data;
  logic [1:0]  s5_col_idx;
  logic        s5_top_valid, s5_top_ready, s5_top_last;
  logic [2:0]  s5_top_data;
  logic [2:0]  s5_top_idx;
  logic        s5_bot_valid, s5_bot_ready, s5_bot_last;
  logic [2:0]  s5_bot_data;
  logic [2:0]  s5_bot_idx;

  // Split mode, ROWS=4 COLS=2
  logic        s4_wren, s4_loaded, s4_done;
  logic [7:0]  s4_data;
  logic        s4_col_valid, s4_col_ready, s4_col_last;
  logic [3:0]  s4_col_data;
  logic [0:0]  s4_col_idx;
  logic        s4_top_valid, s4_top_ready, s4_top_last;
  logic [1:0]  s4_top_data;
  logic [1:0]  s4_top_idx;
  logic        s4_bot_valid, s4_bot_ready, s4_bot_last;
  logic [1:0]  s4_bot_data;
  logic [1:0]  s4_bot_idx;

  bmp_slicer #(.ROWS(4), .COLS(3), .SPLIT_ROWS(0)) u_n (
    .clk(clk), .reset(reset), .wren(n_wren), .data(n_data),
    .loaded(n_loaded), .done(n_done),
    .col_valid(n_col_valid), .col_ready(n_col_ready), .col_data(n_col_data),
    .col_idx(n_col_idx), .col_last(n_col_last),
    .top_valid(n_top_valid), .top_ready(n_top_ready), .top_data(n_top_data),
    .top_idx(n_top_idx), .top_last(n_top_last),
    .bot_valid(n_bot_valid), .bot_ready(n_bot_ready), .bot_data(n_bot_data),
    .bot_idx(n_bot_idx), .bot_last(n_bot_last)
  );

  bmp_slicer #(.ROWS(5), .COLS(3), .SPLIT_ROWS(1)) u_s5 (
    .clk(clk), .reset(reset), .wren(s5_wren), .data(s5_data),
    .loaded(s5_loaded), .done(s5_done),
    .col_valid(s5_col_valid), .col_ready(s5_col_ready), .col_data(s5_col_data),
    .col_idx(s5_col_idx), .col_last(s5_col_last),
    .top_valid(s5_top_valid), .top_ready(s5_top_ready), .top_data(s5_top_data),
    .top_idx(s5_top_idx), .top_last(s5_top_last),
    .bot_valid(s5_bot_valid), .bot_ready(s5_bot_ready), .bot_data(s5_bot_data),
    .bot_idx(s5_bot_idx), .bot_last(s5_bot_last)
  );

  bmp_slicer #(.ROWS(4), .COLS(2), .SPLIT_ROWS(1)) u_s4 (
    .clk(clk), .reset(reset), .wren(s4_wren), .data(s4_data),
    .loaded(s4_loaded), .done(s4_done),
    .col_valid(s4_col_valid), .col_ready(s4_col_ready), .col_data(s4_col_data),
    .col_idx(s4_col_idx), .col_last(s4_col_last),
    .top_valid(s4_top_valid), .top_ready(s4_top_ready), .top_data(s4_top_data),
    .top_idx(s4_top_idx), .top_last(s4_top_last),
    .bot_valid(s4_bot_valid), .bot_ready(s4_bot_ready), .bot_data(s4_bot_data),
    .bot_idx(s4_bot_idx), .bot_last(s4_bot_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          xfers;
  int          bp_rdy [6] = '{0, 0, 1, 0, 1, 1};
  int          bp_idx [6] = '{0, 0, 0, 1, 1, 2};
  logic [3:0]  bp_dat [6] = '{4'b1110, 4'b1110, 4'b1110, 4'b0010, 4'b0010, 4'b1001};

  initial begin
    reset = 1'b1;
    n_wren = 1'b0;  n_data = '0;  n_col_ready = 1'b1;  n_top_ready = 1'b1;  n_bot_ready = 1'b1;
    s5_wren = 1'b0; s5_data = '0; s5_col_ready = 1'b1; s5_top_ready = 1'b1; s5_bot_ready = 1'b1;
    s4_wren = 1'b0; s4_data = '0; s4_col_ready = 1'b1; s4_top_ready = 1'b1; s4_bot_ready = 1'b1;
    tick(); tick(); tick();

    // Reset state
    chk("rst loaded", n_loaded, 0);
    chk("rst done", n_done, 0);
    chk("rst col_valid", n_col_valid, 0);
    chk("rst col_data", n_col_data, 0);
    chk("rst col_idx", n_col_idx, 0);
    chk("rst top_idx", n_top_idx, 3);
    chk("rst bot_idx", n_bot_idx, 0);
    chk("rst top_last", n_top_last, 0);
    chk("rst s5 top_idx", s5_top_idx, 4);
    chk("rst s5 top_last", s5_top_last, 0);
    chk("rst s4 bot_valid", s4_bot_valid, 0);
    reset = 1'b0;
    tick();

    // Normal load of 12'hA5C, all ready high
    n_data = 12'hA5C; n_wren = 1'b1;
    tick();
    n_wren = 1'b0;
    chk("n1 loaded", n_loaded, 1);
    chk("n1 col_valid", n_col_valid, 1);
    chk("n1 col_data", n_col_data, 4'b1110);
    chk("n1 col_idx", n_col_idx, 0);
    chk("n1 col_last", n_col_last, 0);
    chk("n1 bot_data", n_bot_data, 3'h4);
    chk("n1 top_data", n_top_data, 3'h5);
    chk("n1 top_idx", n_top_idx, 3);
    tick();
    chk("n2 loaded", n_loaded, 0);
    chk("n2 col_data", n_col_data, 4'b0010);
    chk("n2 col_idx", n_col_idx, 1);
    chk("n2 bot_data", n_bot_data, 3'h3);
    chk("n2 top_data", n_top_data, 3'h1);
    tick();
    chk("n3 col_data", n_col_data, 4'b1001);
    chk("n3 col_last", n_col_last, 1);
    chk("n3 bot_data", n_bot_data, 3'h1);
    chk("n3 bot_idx", n_bot_idx, 2);
    chk("n3 top_data", n_top_data, 3'h3);
    chk("n3 top_last", n_top_last, 0);
    tick();
    chk("n4 col_valid", n_col_valid, 0);
    chk("n4 col_data", n_col_data, 0);
    chk("n4 col_last", n_col_last, 0);
    chk("n4 bot_data", n_bot_data, 3'h5);
    chk("n4 bot_last", n_bot_last, 1);
    chk("n4 top_data", n_top_data, 3'h4);
    chk("n4 top_idx", n_top_idx, 0);
    chk("n4 top_last", n_top_last, 1);
    chk("n4 done", n_done, 0);
    tick();
    chk("n5 bot_valid", n_bot_valid, 0);
    chk("n5 top_valid", n_top_valid, 0);
    chk("n5 done", n_done, 1);

    // Back-pressure on the column stream
    n_col_ready = 1'b0; n_wren = 1'b1;
    tick();
    n_wren = 1'b0;
    chk("bp done cleared", n_done, 0);
    xfers = 0;
    for (int i = 0; i < 6; i++) begin
      n_col_ready = (bp_rdy[i] != 0);
      #1;
      chk($sformatf("bp%0d col_valid", i), n_col_valid, 1);
      chk($sformatf("bp%0d col_idx", i), n_col_idx, bp_idx[i]);
      chk($sformatf("bp%0d col_data", i), n_col_data, bp_dat[i]);
      if (n_col_valid && n_col_ready) xfers++;
      tick();
    end
    chk("bp transfers", xfers, 3);
    chk("bp col_valid end", n_col_valid, 0);
    chk("bp done", n_done, 1);

    // Reload mid-stream with col_ready high in the load cycle
    n_col_ready = 1'b1; n_data = 12'hA5C; n_wren = 1'b1;
    tick();
    n_wren = 1'b0;
    tick();
    chk("rl pre col_idx", n_col_idx, 1);
    chk("rl pre col_data", n_col_data, 4'b0010);
    n_data = 12'h0F0; n_wren = 1'b1;
    tick();
    n_wren = 1'b0;
    chk("rl loaded", n_loaded, 1);
    chk("rl col_idx", n_col_idx, 0);
    chk("rl col_data", n_col_data, 4'b0100);
    chk("rl bot_data", n_bot_data, 3'h0);
    chk("rl top_idx", n_top_idx, 3);
    chk("rl done", n_done, 0);
    tick();
    chk("rl2 col_idx", n_col_idx, 1);
    chk("rl2 col_data", n_col_data, 4'b0110);
    chk("rl2 bot_data", n_bot_data, 3'h6);
    tick(); tick();
    chk("rl4 done", n_done, 0);
    tick();
    chk("rl5 done", n_done, 1);

    // Reset with wren in the same cycle, mid-stream
    n_data = 12'hA5C; n_wren = 1'b1;
    tick();
    n_wren = 1'b0;
    tick();
    reset = 1'b1; n_wren = 1'b1; n_data = 12'h0F0;
    tick();
    chk("rw loaded", n_loaded, 0);
    chk("rw col_valid", n_col_valid, 0);
    chk("rw top_valid", n_top_valid, 0);
    chk("rw bot_valid", n_bot_valid, 0);
    chk("rw col_idx", n_col_idx, 0);
    chk("rw bot_idx", n_bot_idx, 0);
    chk("rw top_idx", n_top_idx, 3);
    chk("rw done", n_done, 0);
    chk("rw bot_data", n_bot_data, 0);
    reset = 1'b0; n_wren = 1'b0;
    tick();
    chk("rw idle col_valid", n_col_valid, 0);
    n_data = 12'hA5C; n_wren = 1'b1;
    tick();
    n_wren = 1'b0;
    chk("rw2 loaded", n_loaded, 1);
    chk("rw2 col_data", n_col_data, 4'b1110);
    chk("rw2 top_data", n_top_data, 3'h5);

    // Split mode, 5 rows: bot takes rows 0..2, top takes 4,3
    s5_data = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1}; s5_wren = 1'b1;
    tick();
    s5_wren = 1'b0;
    chk("s5a loaded", s5_loaded, 1);
    chk("s5a col_data", s5_col_data, 5'b10101);
    chk("s5a col_idx", s5_col_idx, 0);
    chk("s5a bot_data", s5_bot_data, 1);
    chk("s5a bot_idx", s5_bot_idx, 0);
    chk("s5a top_valid", s5_top_valid, 1);
    chk("s5a top_data", s5_top_data, 5);
    chk("s5a top_last", s5_top_last, 0);
    tick();
    chk("s5b bot_data", s5_bot_data, 2);
    chk("s5b top_data", s5_top_data, 4);
    chk("s5b top_idx", s5_top_idx, 3);
    chk("s5b top_last", s5_top_last, 0);
    tick();
    chk("s5c bot_valid", s5_bot_valid, 1);
    chk("s5c bot_idx", s5_bot_idx, 2);
    chk("s5c bot_data", s5_bot_data, 3);
    chk("s5c bot_last", s5_bot_last, 1);
    chk("s5c top_valid", s5_top_valid, 0);
    chk("s5c top_data", s5_top_data, 0);
    chk("s5c col_last", s5_col_last, 1);
    chk("s5c done", s5_done, 0);
    tick();
    chk("s5d bot_valid", s5_bot_valid, 0);
    chk("s5d col_valid", s5_col_valid, 0);
    chk("s5d done", s5_done, 1);

    // Split mode, 4 rows: simultaneous meet finishes both row streams
    s4_data = {2'd2, 2'd3, 2'd2, 2'd1}; s4_wren = 1'b1;
    tick();
    s4_wren = 1'b0;
    chk("s4a loaded", s4_loaded, 1);
    chk("s4a col_data", s4_col_data, 4'b0101);
    chk("s4a bot_data", s4_bot_data, 1);
    chk("s4a top_data", s4_top_data, 2);
    chk("s4a top_last", s4_top_last, 0);
    tick();
    chk("s4b col_idx", s4_col_idx, 1);
    chk("s4b col_data", s4_col_data, 4'b1110);
    chk("s4b col_last", s4_col_last, 1);
    chk("s4b bot_idx", s4_bot_idx, 1);
    chk("s4b bot_data", s4_bot_data, 2);
    chk("s4b bot_last", s4_bot_last, 0);
    chk("s4b top_idx", s4_top_idx, 2);
    chk("s4b top_data", s4_top_data, 3);
    chk("s4b top_last", s4_top_last, 0);
    s4_bot_ready = 1'b0;
    #1;
    chk("s4b top_last bot stalled", s4_top_last, 1);
    chk("s4b top_valid bot stalled", s4_top_valid, 1);
    s4_bot_ready = 1'b1;
    #1;
    chk("s4b done", s4_done, 0);
    tick();
    chk("s4c bot_valid", s4_bot_valid, 0);
    chk("s4c top_valid", s4_top_valid, 0);
    chk("s4c col_valid", s4_col_valid, 0);
    chk("s4c done", s4_done, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
